flow_sequencer: RTL and testbench

Instruction flow-control unit for the MC14500B core. It drives the ProgramCounter's jump port (`write`, `address_in`) from the instruction currently addressed by the PC. It decodes JMP, RTN and SKZ, and maintains the skip state that suppresses one instruction. An optional hardware return stack turns JMP/RTN into call/return.

---
 rtl/flow_sequencer.sv | 110 +++++++++++
 tb/tb_flow_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/flow_sequencer.sv
// rtl/flow_sequencer.sv - MC14500B flow control: JMP/RTN/SKZ decode, skip state, optional return stack (RETURN_STACK_EN)
module flow_sequencer #(
  parameter int SIZE_LOG    = 8,
  parameter int STACK_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [3:0]                         opcode,
  input  logic [SIZE_LOG-1:0]                operand,
  input  logic [SIZE_LOG-1:0]                address,
  input  logic                               rr,
  output logic                               write,
  output logic [SIZE_LOG-1:0]                address_in,
  output logic                               skip,
  output logic                               jmp_flag,
  output logic                               rtn_flag,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   depth,
  output logic                               overflow,
  output logic                               underflow
);

  localparam int DW = $clog2(STACK_DEPTH+1);

  // NOPO (0x0), NOPF (0xF) and all other opcodes have no flow effect.
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_RTN = 4'hD;
  localparam logic [3:0] OP_SKZ = 4'hE;

  // An instruction is live when it is neither suppressed nor held in reset.
  logic live;
  logic jmp_live;
  logic rtn_live;

  assign live     = !rst && !skip;
  assign jmp_live = live && (opcode == OP_JMP);
  assign rtn_live = live && (opcode == OP_RTN);
  assign jmp_flag = jmp_live;
  assign rtn_flag = rtn_live;

  // Skip lasts exactly one instruction; a suppressed RTN/SKZ cannot re-arm it.
  always_ff @(posedge clk) begin
    if (rst) begin
      skip <= 1'b0;
    end else if (skip) begin
      skip <= 1'b0;
    end else if (opcode == OP_RTN) begin
      skip <= 1'b1;
    end else if (opcode == OP_SKZ && !rr) begin
      skip <= 1'b1;
    end else begin
      skip <= 1'b0;
    end
  end

`ifdef RETURN_STACK_EN
  logic [SIZE_LOG-1:0] stack [STACK_DEPTH];
  logic [SIZE_LOG-1:0] top;
  logic                empty;
  logic                full;

  assign empty = (depth == '0);
  assign full  = (depth == DW'(STACK_DEPTH));

  // Select the most recent entry; the loop avoids an index narrower than depth.
  always_comb begin
    top = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (DW'(i) == depth - DW'(1)) top = stack[i];
    end
  end

  // An empty-stack RTN falls back to the native behaviour: no jump.
  assign write      = jmp_live || (rtn_live && !empty);
  assign address_in = (rtn_live && !empty) ? top : operand;

  // Stack pointer and sticky error flags; reset discards all entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      depth     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (jmp_live) begin
      if (full) overflow <= 1'b1;
      else      depth    <= depth + DW'(1);
    end else if (rtn_live) begin
      if (empty) underflow <= 1'b1;
      else       depth     <= depth - DW'(1);
    end
  end

  // Return-address storage; contents above the pointer are never read, so no clear.
  always_ff @(posedge clk) begin
    if (jmp_live && !full) begin
      for (int i = 0; i < STACK_DEPTH; i++) begin
        if (DW'(i) == depth) stack[i] <= address + SIZE_LOG'(1);
      end
    end
  end
`else
  logic unused_address;

  assign unused_address = ^address;
  assign write          = jmp_live;
  assign address_in     = operand;
  assign depth          = '0;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_flow_sequencer.sv
// tb/tb_flow_sequencer.sv - directed bench for flow_sequencer, both RETURN_STACK_EN builds
module tb_flow_sequencer;

`ifdef RETURN_STACK_EN
  localparam bit EN = 1'b1;
`else
  localparam bit EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] opcode = 4'h0;
  logic [7:0] operand = 8'h00;
  logic [7:0] address = 8'h00;
  logic       rr = 1'b0;
  logic       write;
  logic [7:0] address_in;
  logic       skip;
  logic       jmp_flag;
  logic       rtn_flag;
  logic [2:0] depth;
  logic       overflow;
  logic       underflow;

  int vectors = 0;
  int miscompares = 0;

  flow_sequencer #(.SIZE_LOG(8), .STACK_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .operand(operand), .address(address), .rr(rr),
    .write(write), .address_in(address_in), .skip(skip), .jmp_flag(jmp_flag),
    .rtn_flag(rtn_flag), .depth(depth), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Present one instruction just after the falling edge.
  task automatic drive(input logic [3:0] op, input logic [7:0] opr, input logic [7:0] adr, input logic r);
    @(negedge clk);
    opcode = op; operand = opr; address = adr; rr = r;
    #1;
  endtask

  // Retire it on the rising edge and settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(4'hC, 8'h22, 8'h05, 1'b0);
      vectors++; if (write !== 1'b0) begin miscompares++; $display("FAIL rst_write c%0d got %b want 0", i, write); end
      vectors++; if (jmp_flag !== 1'b0) begin miscompares++; $display("FAIL rst_jmp_flag c%0d got %b want 0", i, jmp_flag); end
      tick();
    end
    rst = 1'b0;
    drive(4'h0, 8'h00, 8'h00, 1'b0);
    vectors++; if (skip !== 1'b0) begin miscompares++; $display("FAIL rst_skip got %b want 0", skip); end
    vectors++; if (depth !== 3'd0) begin miscompares++; $display("FAIL rst_depth got %0d want 0", depth); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL rst_overflow got %b want 0", overflow); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL rst_underflow got %b want 0", underflow); end
    tick();
  endtask

  task automatic test_call_return();
    drive(4'hC, 8'h40, 8'h10, 1'b0);
    vectors++; if (write !== 1'b1) begin miscompares++; $display("FAIL call_write got %b want 1", write); end
    vectors++; if (address_in !== 8'h40) begin miscompares++; $display("FAIL call_addr got %h want 40", address_in); end
    vectors++; if (jmp_flag !== 1'b1) begin miscompares++; $display("FAIL call_jmp_flag got %b want 1", jmp_flag); end
    vectors++; if (rtn_flag !== 1'b0) begin miscompares++; $display("FAIL call_rtn_flag got %b want 0", rtn_flag); end
    tick();
    vectors++; if (depth !== (EN ? 3'd1 : 3'd0)) begin miscompares++; $display("FAIL call_depth got %0d want %0d", depth, EN ? 1 : 0); end
    drive(4'hD, 8'h00, 8'h45, 1'b0);
    vectors++; if (write !== EN) begin miscompares++; $display("FAIL rtn_write got %b want %b", write, EN); end
    vectors++; if (address_in !== (EN ? 8'h11 : 8'h00)) begin miscompares++; $display("FAIL rtn_addr got %h want %h", address_in, EN ? 8'h11 : 8'h00); end
    vectors++; if (rtn_flag !== 1'b1) begin miscompares++; $display("FAIL rtn_flag got %b want 1", rtn_flag); end
    tick();
    vectors++; if (depth !== 3'd0) begin miscompares++; $display("FAIL rtn_depth got %0d want 0", depth); end
    vectors++; if (skip !== 1'b1) begin miscompares++; $display("FAIL rtn_skip got %b want 1", skip); end
    drive(4'h1, 8'h00, 8'h12, 1'b0);
    vectors++; if (skip !== 1'b1) begin miscompares++; $display("FAIL ld_skip got %b want 1", skip); end
    tick();
    vectors++; if (skip !== 1'b0) begin miscompares++; $display("FAIL ld_skip_clear got %b want 0", skip); end
  endtask

  task automatic test_skip();
    drive(4'hE, 8'h00, 8'h20, 1'b0);
    tick();
    vectors++; if (skip !== 1'b1) begin miscompares++; $display("FAIL skz0_skip got %b want 1", skip); end
    drive(4'hC, 8'h80, 8'h21, 1'b0);
    vectors++; if (write !== 1'b0) begin miscompares++; $display("FAIL skz0_jmp_write got %b want 0", write); end
    vectors++; if (jmp_flag !== 1'b0) begin miscompares++; $display("FAIL skz0_jmp_flag got %b want 0", jmp_flag); end
    vectors++; if (address_in !== 8'h80) begin miscompares++; $display("FAIL skz0_addr got %h want 80", address_in); end
    tick();
    vectors++; if (depth !== 3'd0) begin miscompares++; $display("FAIL skz0_depth got %0d want 0", depth); end
    vectors++; if (skip !== 1'b0) begin miscompares++; $display("FAIL skz0_skip_clear got %b want 0", skip); end
    drive(4'hE, 8'h00, 8'h22, 1'b1);
    tick();
    vectors++; if (skip !== 1'b0) begin miscompares++; $display("FAIL skz1_skip got %b want 0", skip); end
    drive(4'hC, 8'h80, 8'h23, 1'b1);
    vectors++; if (write !== 1'b1) begin miscompares++; $display("FAIL skz1_jmp_write got %b want 1", write); end
    vectors++; if (jmp_flag !== 1'b1) begin miscompares++; $display("FAIL skz1_jmp_flag got %b want 1", jmp_flag); end
    tick();
    vectors++; if (depth !== (EN ? 3'd1 : 3'd0)) begin miscompares++; $display("FAIL skz1_depth got %0d want %0d", depth, EN ? 1 : 0); end
    // Suppressed RTN: no flags, no pop, and it does not re-arm skip.
    drive(4'hE, 8'h00, 8'h80, 1'b0);
    tick();
    drive(4'hD, 8'h00, 8'h81, 1'b0);
    vectors++; if (rtn_flag !== 1'b0) begin miscompares++; $display("FAIL srtn_flag got %b want 0", rtn_flag); end
    vectors++; if (write !== 1'b0) begin miscompares++; $display("FAIL srtn_write got %b want 0", write); end
    tick();
    vectors++; if (skip !== 1'b0) begin miscompares++; $display("FAIL srtn_skip got %b want 0", skip); end
    vectors++; if (depth !== (EN ? 3'd1 : 3'd0)) begin miscompares++; $display("FAIL srtn_depth got %0d want %0d", depth, EN ? 1 : 0); end
    rst = 1'b1;
    drive(4'h0, 8'h00, 8'h00, 1'b0);
    tick();
    rst = 1'b0;
  endtask

  task automatic test_stack_limits();
    for (int i = 0; i < 5; i++) begin
      drive(4'hC, 8'h10 + 8'(i), 8'(i), 1'b0);
      vectors++; if (write !== 1'b1) begin miscompares++; $display("FAIL push%0d_write got %b want 1", i, write); end
      tick();
      if (i == 3) begin
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL push3_overflow got %b want 0", overflow); end
      end
    end
    vectors++; if (depth !== (EN ? 3'd4 : 3'd0)) begin miscompares++; $display("FAIL full_depth got %0d want %0d", depth, EN ? 4 : 0); end
    vectors++; if (overflow !== EN) begin miscompares++; $display("FAIL full_overflow got %b want %b", overflow, EN); end
    for (int i = 0; i < 4; i++) begin
      drive(4'hD, 8'hA0, 8'h50 + 8'(i), 1'b0);
      vectors++; if (write !== EN) begin miscompares++; $display("FAIL pop%0d_write got %b want %b", i, write, EN); end
      vectors++; if (address_in !== (EN ? 8'(4 - i) : 8'hA0)) begin miscompares++; $display("FAIL pop%0d_addr got %h want %h", i, address_in, EN ? 8'(4 - i) : 8'hA0); end
      tick();
      drive(4'h0, 8'h00, 8'h60, 1'b0);
      tick();
    end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL pre_under got %b want 0", underflow); end
    drive(4'hD, 8'hA0, 8'h70, 1'b0);
    vectors++; if (write !== 1'b0) begin miscompares++; $display("FAIL under_write got %b want 0", write); end
    vectors++; if (rtn_flag !== 1'b1) begin miscompares++; $display("FAIL under_rtn_flag got %b want 1", rtn_flag); end
    tick();
    vectors++; if (underflow !== EN) begin miscompares++; $display("FAIL under_flag got %b want %b", underflow, EN); end
    vectors++; if (skip !== 1'b1) begin miscompares++; $display("FAIL under_skip got %b want 1", skip); end
    vectors++; if (depth !== 3'd0) begin miscompares++; $display("FAIL under_depth got %0d want 0", depth); end
  endtask

  task automatic test_reset_mid();
    drive(4'h0, 8'h00, 8'h71, 1'b0);
    tick();
    drive(4'hC, 8'h33, 8'h72, 1'b0);
    tick();
    drive(4'hE, 8'h00, 8'h33, 1'b0);
    tick();
    rst = 1'b1;
    drive(4'hC, 8'h44, 8'h34, 1'b0);
    vectors++; if (write !== 1'b0) begin miscompares++; $display("FAIL mid_write got %b want 0", write); end
    tick();
    rst = 1'b0;
    vectors++; if (skip !== 1'b0) begin miscompares++; $display("FAIL mid_skip got %b want 0", skip); end
    vectors++; if (depth !== 3'd0) begin miscompares++; $display("FAIL mid_depth got %0d want 0", depth); end
    vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL mid_overflow got %b want 0", overflow); end
    vectors++; if (underflow !== 1'b0) begin miscompares++; $display("FAIL mid_underflow got %b want 0", underflow); end
  endtask

  task automatic test_wrap();
    drive(4'hC, 8'h30, 8'hFF, 1'b0);
    vectors++; if (address_in !== 8'h30) begin miscompares++; $display("FAIL wrap_jmp_addr got %h want 30", address_in); end
    tick();
    drive(4'hD, 8'h55, 8'h30, 1'b0);
    vectors++; if (write !== EN) begin miscompares++; $display("FAIL wrap_write got %b want %b", write, EN); end
    vectors++; if (address_in !== (EN ? 8'h00 : 8'h55)) begin miscompares++; $display("FAIL wrap_addr got %h want %h", address_in, EN ? 8'h00 : 8'h55); end
    tick();
    vectors++; if (depth !== 3'd0) begin miscompares++; $display("FAIL wrap_depth got %0d want 0", depth); end
  endtask

  initial begin
    test_reset();
    test_call_return();
    test_skip();
    test_stack_limits();
    test_reset_mid();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
